gfcm_sched: RTL and testbench
=============================

// Module: gfcm_sched
// PURPOSE
//  Clock-source scheduler for the glitch-free clock mux (gfcm). Runs on an always-on reference
//  clock and drives the gfcm sel line: 0 = slow clock (clk1), 1 = fast clock (clk2).
//  Arbitrates fast-clock requests from N_REQ requesters using a 4-phase req/ack handshake.
//  Enforces a settle time on every switch and a minimum fast dwell; force_slow is an override
//  for low-power entry. Does not drive the gfcm async reset.
// PARAMETERS
//  N_REQ          4   number of fast-clock requesters
//  SETTLE_CYCLES  8   clk cycles held in each transition state (>=1); covers gfcm handover
//  MIN_DWELL      16  min clk cycles in FAST before a voluntary return to slow (>=1)
//  CNT_W          16  width of switch_count
// PORTS
//  clk           in   1      always-on reference clock
//  reset_n       in   1      reset, synchronous, active-low
//  fast_req      in   N_REQ  per-requester fast-clock request (level, 4-phase)
//  force_slow    in   1      override: go to / stay on slow clock
//  fast_ack      out  N_REQ  per-requester grant: fast clock is stable
//  sel_out       out  1      to gfcm sel
//  busy          out  1      switch in progress (TO_FAST or TO_SLOW)
//  state_o       out  2      FSM state, for debug/status
//  switch_count  out  CNT_W  completed switches (either direction), saturating
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): state SLOW, sel_out=0, fast_ack=0, busy=0, timers=0,
//   switch_count=0. Reset mid-switch aborts immediately; sel_out drops that edge.
//  States: SLOW=0, TO_FAST=1, FAST=2, TO_SLOW=3. All outputs are registered.
//  SLOW: if |fast_req && !force_slow -> TO_FAST; sel_out<=1; timer<=SETTLE_CYCLES-1.
//  TO_FAST: timer decrements each cycle; after exactly SETTLE_CYCLES cycles -> FAST, and
//   dwell<=MIN_DWELL-1. Not abortable by fast_req or force_slow.
//  FAST: fast_ack[i]<=fast_req[i] & ~force_slow each cycle. All requests active on FAST entry
//   are acked on the entry edge. dwell decrements and saturates at 0.
//   Exit when force_slow, or when fast_req==0 && dwell==0: -> TO_SLOW; sel_out<=0;
//   fast_ack<=0; timer<=SETTLE_CYCLES-1. force_slow ignores dwell and drops acks on the
//   same edge even while req is high.
//  TO_SLOW: runs for exactly SETTLE_CYCLES cycles, then -> SLOW. Not abortable. Requests
//   arriving here wait in SLOW.
//  Ack latency: req sampled high in SLOW at edge t -> sel_out=1 at t+1, ack at t+1+SETTLE_CYCLES.
//  Ack deassert: one edge after req is sampled low. Ack is never high outside FAST.
//  force_slow in SLOW: requests stay pending, no ack. Release -> TO_FAST on the next edge
//   if any req is high.
//  busy = (state==TO_FAST || state==TO_SLOW).
//  switch_count increments on entry to FAST and on entry to SLOW from TO_SLOW; holds at
//   2**CNT_W-1.
// STRUCTURE
//  gfcm_pkg: typedef enum logic [1:0] sched_state_t {SLOW,TO_FAST,FAST,TO_SLOW};
//   localparams SEL_SLOW=1'b0, SEL_FAST=1'b1.
//  Sub-module sched_timer: loadable down-counter with a zero flag, width
//   $clog2(max(SETTLE_CYCLES,MIN_DWELL)+1). Two instances: settle and dwell.
//  Top level: FSM, ack register, saturating switch counter.
// TESTING (N_REQ=4, SETTLE=8, DWELL=16, CNT_W=16 unless noted)
//  1. reset_n=0 for 2 edges from random state -> sel_out=0, fast_ack=4'h0, busy=0, state_o=0, count=0.
//  2. fast_req=4'h1 sampled at edge 0 -> sel_out=1 and busy=1 at edge 1; state_o=2,
//     fast_ack=4'h1, busy=0 at edge 9; switch_count=1.
//  3. From (2), fast_req=0 at edge 10 -> ack=0 at edge 11; sel_out=0 at edge 25 (dwell);
//     state SLOW at edge 33; switch_count=2.
//  4. fast_req=4'h4 raised at edge 27 (TO_SLOW) -> no abort; SLOW at 33, TO_FAST at 34,
//     fast_ack=4'h4 at 42.
//  5. FAST with fast_req=4'h2, force_slow=1 at edge e -> at e+1 ack=0, sel_out=0, TO_SLOW.
//     While force held: stays SLOW, ack=0. Release -> TO_FAST on the next edge.
//  6. CNT_W=2, 5 full fast/slow switches -> switch_count saturates at 3.
//     Assert always: ack!=0 implies state==FAST.

Source files
------------

// File: rtl/gfcm_pkg.sv
// Shared definitions for the gfcm clock-source scheduler.
//   sched_state_t : scheduler FSM encoding (also exported on state_o)
//   SEL_SLOW/FAST : gfcm sel line values
//   max_int       : helper used to size the shared timer width
package gfcm_pkg;

    typedef enum logic [1:0] {
        SLOW    = 2'd0,
        TO_FAST = 2'd1,
        FAST    = 2'd2,
        TO_SLOW = 2'd3
    } sched_state_t;

    localparam logic SEL_SLOW = 1'b0;
    localparam logic SEL_FAST = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter with a zero flag, used for settle and dwell timing.
//   clk        : reference clock
//   reset_n    : synchronous active-low reset (count -> 0)
//   load_i     : load load_val_i this edge (takes priority over decrement)
//   load_val_i : value to load
//   dec_i      : decrement this edge; the count saturates at 0
//   zero_o     : count is currently 0
module sched_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gfcm_sched.sv
// Clock-source scheduler for the glitch-free clock mux. Runs on the always-on
// reference clock and steers the gfcm sel line between slow (0) and fast (1).
//   clk          : always-on reference clock
//   reset_n      : synchronous active-low reset
//   fast_req     : per-requester fast-clock request (4-phase level)
//   force_slow   : override, go to / stay on the slow clock
//   fast_ack     : per-requester grant, asserted only while FAST
//   sel_out      : gfcm sel
//   busy         : a switch is in progress (TO_FAST or TO_SLOW)
//   state_o      : FSM state for debug/status
//   switch_count : completed switches in either direction, saturating
module gfcm_sched
    import gfcm_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int MIN_DWELL     = 16,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] fast_req,
    input  logic             force_slow,
    output logic [N_REQ-1:0] fast_ack,
    output logic             sel_out,
    output logic             busy,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] switch_count
);

    localparam int TMR_W = $clog2(max_int(SETTLE_CYCLES, MIN_DWELL) + 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DWELL_LOAD  = TMR_W'(MIN_DWELL - 1);

    sched_state_t     state_q, state_d;
    logic             sel_q, sel_d;
    logic             busy_q, busy_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic settle_load, settle_zero;
    logic dwell_load, dwell_zero;
    logic cnt_inc;

    logic [N_REQ-1:0] req_granted;
    assign req_granted = fast_req & ~{N_REQ{force_slow}};

    // Settle timer only counts during transitions; the dwell timer only in FAST.
    sched_timer #(.W(TMR_W)) u_settle (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (settle_load),
        .load_val_i (SETTLE_LOAD),
        .dec_i      ((state_q == TO_FAST) || (state_q == TO_SLOW)),
        .zero_o     (settle_zero)
    );

    sched_timer #(.W(TMR_W)) u_dwell (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (dwell_load),
        .load_val_i (DWELL_LOAD),
        .dec_i      (state_q == FAST),
        .zero_o     (dwell_zero)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ack_d       = '0;
        settle_load = 1'b0;
        dwell_load  = 1'b0;
        cnt_inc     = 1'b0;

        unique case (state_q)
            SLOW: begin
                if ((|fast_req) && !force_slow) begin
                    state_d     = TO_FAST;
                    sel_d       = SEL_FAST;
                    settle_load = 1'b1;
                end
            end
            TO_FAST: begin
                // The load value is SETTLE_CYCLES-1, so leaving on the zero
                // flag gives exactly SETTLE_CYCLES cycles in this state.
                if (settle_zero) begin
                    state_d    = FAST;
                    dwell_load = 1'b1;
                    ack_d      = req_granted;
                    cnt_inc    = 1'b1;
                end
            end
            FAST: begin
                if (force_slow || ((fast_req == '0) && dwell_zero)) begin
                    state_d     = TO_SLOW;
                    sel_d       = SEL_SLOW;
                    settle_load = 1'b1;
                end else begin
                    ack_d = req_granted;
                end
            end
            TO_SLOW: begin
                if (settle_zero) begin
                    state_d = SLOW;
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_d = SLOW;
                sel_d   = SEL_SLOW;
            end
        endcase

        busy_d = (state_d == TO_FAST) || (state_d == TO_SLOW);
        cnt_d  = (cnt_inc && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= SLOW;
            sel_q   <= SEL_SLOW;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fast_ack     = ack_q;
    assign sel_out      = sel_q;
    assign busy         = busy_q;
    assign state_o      = state_q;
    assign switch_count = cnt_q;

endmodule

// File: tb/tb_gfcm_sched.sv
// Directed bench for gfcm_sched: a default-parameter instance for timing and
// a small instance (CNT_W=2, SETTLE=2, DWELL=1) for counter saturation.
module tb_gfcm_sched;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] fast_req;
    logic       force_slow;
    logic [3:0] fast_ack;
    logic       sel_out, busy;
    logic [1:0] state_o;
    logic [15:0] switch_count;

    logic [3:0] req2;
    logic [3:0] ack2;
    logic       sel2, busy2;
    logic [1:0] state2;
    logic [1:0] count2;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    gfcm_sched dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fast_req     (fast_req),
        .force_slow   (force_slow),
        .fast_ack     (fast_ack),
        .sel_out      (sel_out),
        .busy         (busy),
        .state_o      (state_o),
        .switch_count (switch_count)
    );

    gfcm_sched #(.N_REQ(4), .SETTLE_CYCLES(2), .MIN_DWELL(1), .CNT_W(2)) dut_sat (
        .clk          (clk),
        .reset_n      (reset_n),
        .fast_req     (req2),
        .force_slow   (1'b0),
        .fast_ack     (ack2),
        .sel_out      (sel2),
        .busy         (busy2),
        .state_o      (state2),
        .switch_count (count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ack must never be visible outside FAST, on either instance.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check("ack_only_in_fast", 32'((fast_ack == 4'h0) || (state_o == 2'd2)), 32'h1);
            check("ack2_only_in_fast", 32'((ack2 == 4'h0) || (state2 == 2'd2)), 32'h1);
        end
    end

    initial begin
        reset_n    = 1'b0;
        fast_req   = 4'h0;
        force_slow = 1'b0;
        req2       = 4'h0;
        step(2);
        reset_n = 1'b1;

        // Drive into FAST with several requesters, then reset from there.
        fast_req = 4'hB;
        step(9);
        check("pre_state", 32'(state_o), 32'h2);
        check("pre_ack_multi", 32'(fast_ack), 32'hB);
        check("pre_count", 32'(switch_count), 32'h1);
        reset_n  = 1'b0;
        fast_req = 4'h0;
        step(1);
        check("rst_sel", 32'(sel_out), 32'h0);
        check("rst_ack", 32'(fast_ack), 32'h0);
        step(1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_state", 32'(state_o), 32'h0);
        check("rst_count", 32'(switch_count), 32'h0);
        reset_n = 1'b1;

        // Edge 0: request from requester 0.
        fast_req = 4'h1;
        step(1);                                       // edge 1
        check("e1_sel", 32'(sel_out), 32'h1);
        check("e1_busy", 32'(busy), 32'h1);
        check("e1_state", 32'(state_o), 32'h1);
        check("e1_ack", 32'(fast_ack), 32'h0);
        step(7);                                       // edge 8
        check("e8_state", 32'(state_o), 32'h1);
        check("e8_ack", 32'(fast_ack), 32'h0);
        step(1);                                       // edge 9
        check("e9_state", 32'(state_o), 32'h2);
        check("e9_ack", 32'(fast_ack), 32'h1);
        check("e9_busy", 32'(busy), 32'h0);
        check("e9_count", 32'(switch_count), 32'h1);
        step(1);                                       // edge 10
        check("e10_ack", 32'(fast_ack), 32'h1);
        fast_req = 4'h0;
        step(1);                                       // edge 11
        check("e11_ack", 32'(fast_ack), 32'h0);
        check("e11_state", 32'(state_o), 32'h2);
        step(13);                                      // edge 24: dwell not yet expired
        check("e24_state", 32'(state_o), 32'h2);
        check("e24_sel", 32'(sel_out), 32'h1);
        step(1);                                       // edge 25
        check("e25_state", 32'(state_o), 32'h3);
        check("e25_sel", 32'(sel_out), 32'h0);
        check("e25_busy", 32'(busy), 32'h1);
        step(2);                                       // edge 27: request during TO_SLOW
        fast_req = 4'h4;
        step(5);                                       // edge 32
        check("e32_state", 32'(state_o), 32'h3);
        step(1);                                       // edge 33
        check("e33_state", 32'(state_o), 32'h0);
        check("e33_count", 32'(switch_count), 32'h2);
        check("e33_busy", 32'(busy), 32'h0);
        step(1);                                       // edge 34
        check("e34_state", 32'(state_o), 32'h1);
        check("e34_sel", 32'(sel_out), 32'h1);
        step(7);                                       // edge 41
        check("e41_ack", 32'(fast_ack), 32'h0);
        step(1);                                       // edge 42
        check("e42_state", 32'(state_o), 32'h2);
        check("e42_ack", 32'(fast_ack), 32'h4);
        check("e42_count", 32'(switch_count), 32'h3);

        // Force_slow while FAST and inside the dwell window.
        fast_req = 4'h2;
        step(1);                                       // edge 43
        check("e43_ack", 32'(fast_ack), 32'h2);
        force_slow = 1'b1;
        step(1);                                       // edge 44
        check("force_state", 32'(state_o), 32'h3);
        check("force_ack", 32'(fast_ack), 32'h0);
        check("force_sel", 32'(sel_out), 32'h0);
        step(8);                                       // edge 52
        check("force_slow_state", 32'(state_o), 32'h0);
        check("force_slow_count", 32'(switch_count), 32'h4);
        step(3);                                       // edge 55: held off in SLOW
        check("force_hold_state", 32'(state_o), 32'h0);
        check("force_hold_ack", 32'(fast_ack), 32'h0);
        check("force_hold_sel", 32'(sel_out), 32'h0);
        force_slow = 1'b0;
        step(1);                                       // edge 56
        check("release_state", 32'(state_o), 32'h1);
        step(8);                                       // edge 64
        check("release_ack", 32'(fast_ack), 32'h2);
        check("release_count", 32'(switch_count), 32'h5);

        // Saturation on the 2-bit counter instance.
        for (int k = 0; k < 5; k++) begin
            req2 = 4'h1;
            step(3);
            check($sformatf("sat_fast_state_%0d", k), 32'(state2), 32'h2);
            check($sformatf("sat_fast_ack_%0d", k), 32'(ack2), 32'h1);
            check($sformatf("sat_fast_count_%0d", k), 32'(count2), (2 * k + 1 > 3) ? 32'h3 : 32'(2 * k + 1));
            req2 = 4'h0;
            step(3);
            check($sformatf("sat_slow_state_%0d", k), 32'(state2), 32'h0);
            check($sformatf("sat_slow_count_%0d", k), 32'(count2), (2 * k + 2 > 3) ? 32'h3 : 32'(2 * k + 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
